// File: rtl/tx_xpause_if.sv
// Pause-frame request handshake between the flow-control scheduler and the
// 10G TX encapsulator: xreq/xon request pair out, xdone completion back.
interface tx_xpause_if;
   logic xreq;
   logic xon;
   logic xdone;

   modport master (output xreq, output xon, input xdone);
   modport slave  (input xreq, input xon, output xdone);
endinterface

// File: rtl/tx_xpause_ctrl.sv
// Local XOFF/XON scheduler for the 10G TX encapsulator: watches RX FIFO fill
// against watermarks, refreshes XOFF before the partner's pause expires.
module tx_xpause_ctrl #(
   parameter int LVL_W      = 12,
   parameter int QUANTA_CYC = 8,
   parameter int XDONE_TO   = 4096
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             fc_en,
   input  logic [LVL_W-1:0] rxfifo_used,
   input  logic [LVL_W-1:0] hi_thresh,
   input  logic [LVL_W-1:0] lo_thresh,
   input  logic [15:0]      pause_quanta,
   input  logic [15:0]      refresh_quanta,
   input  logic             fmac_tx_clr_en,
   tx_xpause_if.master      xp,
   output logic             paused,
   output logic [15:0]      pause_timer,
   output logic [15:0]      xoff_cnt,
   output logic [15:0]      xon_cnt,
   output logic             timeout_err
);

   localparam int PS_W = (QUANTA_CYC > 1) ? $clog2(QUANTA_CYC) : 1;
   localparam int TO_W = (XDONE_TO > 1) ? $clog2(XDONE_TO) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(QUANTA_CYC - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(XDONE_TO - 1);

   typedef enum logic [1:0] {
      IDLE,
      XOFF_REQ,
      PAUSED,
      XON_REQ
   } state_t;

   state_t          state;
   logic [PS_W-1:0] prescaler;
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state       <= IDLE;
         xp.xreq     <= 1'b0;
         xp.xon      <= 1'b0;
         paused      <= 1'b0;
         pause_timer <= '0;
         xoff_cnt    <= '0;
         xon_cnt     <= '0;
         timeout_err <= 1'b0;
         prescaler   <= '0;
         to_cnt      <= '0;
      end else begin
         // NOTE: non-blocking assignments; the later clear below overrides any
         // counter or error update made earlier in the same cycle.
         case (state)
            IDLE: begin
               if (fc_en && rxfifo_used >= hi_thresh) begin
                  state   <= XOFF_REQ;
                  xp.xreq <= 1'b1;
                  xp.xon  <= 1'b0;
                  to_cnt  <= '0;
               end
            end

            PAUSED: begin
               if (prescaler == PS_LAST) begin
                  prescaler <= '0;
                  if (pause_timer != 16'd0) pause_timer <= pause_timer - 16'd1;
               end else begin
                  prescaler <= prescaler + 1'b1;
               end

               if (!fc_en || rxfifo_used <= lo_thresh) begin
                  state   <= XON_REQ;
                  xp.xreq <= 1'b1;
                  xp.xon  <= 1'b1;
                  to_cnt  <= '0;
               end else if (pause_timer <= refresh_quanta) begin
                  state   <= XOFF_REQ;
                  xp.xreq <= 1'b1;
                  xp.xon  <= 1'b0;
                  to_cnt  <= '0;
               end
            end

            XOFF_REQ, XON_REQ: begin
               // A request ends only on completion or timeout; completion wins a tie.
               if (xp.xdone) begin
                  xp.xreq <= 1'b0;
                  if (state == XOFF_REQ) begin
                     state       <= PAUSED;
                     paused      <= 1'b1;
                     pause_timer <= pause_quanta;
                     prescaler   <= '0;
                     xoff_cnt    <= xoff_cnt + 16'd1;
                  end else begin
                     state       <= IDLE;
                     paused      <= 1'b0;
                     pause_timer <= '0;
                     xon_cnt     <= xon_cnt + 16'd1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  state       <= IDLE;
                  xp.xreq     <= 1'b0;
                  paused      <= 1'b0;
                  pause_timer <= '0;
                  timeout_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase

         if (fmac_tx_clr_en) begin
            xoff_cnt    <= '0;
            xon_cnt     <= '0;
            timeout_err <= 1'b0;
         end
      end
   end

endmodule
